// File: rtl/coin_credit_if.sv
// Coin validator / vend / change-dispenser signal bundle for coin_credit_accum.
interface coin_credit_if #(
  parameter int unsigned CREDIT_W = 8
);
  logic                coin_valid;
  logic                coin_n;
  logic                coin_d;
  logic                coin_q;
  logic [CREDIT_W-1:0] price;
  logic                vend_req;
  logic                cancel;
  logic                change_ack;
  logic [CREDIT_W-1:0] credit;
  logic                coin_reject;
  logic                vend;
  logic                vend_short;
  logic                change_valid;
  logic [CREDIT_W-1:0] change_amt;
  logic                busy;

  modport master (
    output coin_valid, coin_n, coin_d, coin_q, price, vend_req, cancel, change_ack,
    input  credit, coin_reject, vend, vend_short, change_valid, change_amt, busy
  );

  modport slave (
    input  coin_valid, coin_n, coin_d, coin_q, price, vend_req, cancel, change_ack,
    output credit, coin_reject, vend, vend_short, change_valid, change_amt, busy
  );
endinterface

// File: rtl/coin_credit_accum.sv
// Coin credit accumulator: decodes coins into a saturating credit and sequences
// vend / cancel / change return with the change dispenser.
module coin_credit_accum #(
  parameter int unsigned CREDIT_W    = 8,
  parameter int unsigned NICKEL_VAL  = 5,
  parameter int unsigned DIME_VAL    = 10,
  parameter int unsigned QUARTER_VAL = 25,
  parameter int unsigned MAX_CREDIT  = 200
) (
  input  logic         clk,
  input  logic         reset,
  coin_credit_if.slave bus
);

  localparam int unsigned SUM_W = CREDIT_W + 1;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_VEND    = 2'd1,
    ST_CHANGE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_amt_q, change_amt_d;
  logic                change_valid_q, change_valid_d;
  logic                coin_reject_q, coin_reject_d;
  logic                vend_q, vend_d;
  logic                vend_short_q, vend_short_d;
  logic                busy_q, busy_d;

  logic                coin_evt;
  logic [SUM_W-1:0]    coin_val;
  logic [SUM_W-1:0]    coin_sum;

  // Coin decode: nickel beats dime beats quarter, one value per cycle.
  always_comb begin
    coin_evt = bus.coin_valid & (bus.coin_n | bus.coin_d | bus.coin_q);
    if (bus.coin_n)      coin_val = SUM_W'(NICKEL_VAL);
    else if (bus.coin_d) coin_val = SUM_W'(DIME_VAL);
    else                 coin_val = SUM_W'(QUARTER_VAL);
    coin_sum = {1'b0, credit_q} + coin_val;
  end

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    change_amt_d   = change_amt_q;
    change_valid_d = change_valid_q;
    coin_reject_d  = 1'b0;
    vend_d         = 1'b0;
    vend_short_d   = 1'b0;

    unique case (state_q)
      ST_COLLECT: begin
        if (bus.cancel) begin
          coin_reject_d = coin_evt;
          if (credit_q != '0) begin
            state_d        = ST_CHANGE;
            change_valid_d = 1'b1;
            change_amt_d   = credit_q;
          end
        end else if (bus.vend_req) begin
          coin_reject_d = coin_evt;
          if (credit_q >= bus.price) begin
            state_d  = ST_VEND;
            vend_d   = 1'b1;
            credit_d = credit_q - bus.price;
          end else begin
            vend_short_d = 1'b1;
          end
        end else if (coin_evt) begin
          if (coin_sum <= SUM_W'(MAX_CREDIT)) credit_d = coin_sum[CREDIT_W-1:0];
          else                                coin_reject_d = 1'b1;
        end
      end

      ST_VEND: begin
        coin_reject_d = coin_evt;
        if (credit_q != '0) begin
          state_d        = ST_CHANGE;
          change_valid_d = 1'b1;
          change_amt_d   = credit_q;
        end else begin
          state_d = ST_COLLECT;
        end
      end

      ST_CHANGE: begin
        coin_reject_d = coin_evt;
        if (bus.change_ack) begin
          state_d        = ST_COLLECT;
          credit_d       = '0;
          change_valid_d = 1'b0;
          change_amt_d   = '0;
        end
      end

      default: state_d = ST_COLLECT;
    endcase

    busy_d = (state_d != ST_COLLECT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_COLLECT;
      credit_q       <= '0;
      change_amt_q   <= '0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      vend_q         <= 1'b0;
      vend_short_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      change_amt_q   <= change_amt_d;
      change_valid_q <= change_valid_d;
      coin_reject_q  <= coin_reject_d;
      vend_q         <= vend_d;
      vend_short_q   <= vend_short_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.credit       = credit_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.vend         = vend_q;
  assign bus.vend_short   = vend_short_q;
  assign bus.change_valid = change_valid_q;
  assign bus.change_amt   = change_amt_q;
  assign bus.busy         = busy_q;

endmodule

// File: doc/coin_credit_accum.md
Name: coin_credit_accum

Overview:
Parametrised successor to the single-cycle coin-value selector. It decodes coin pulses into values, accumulates a saturating credit, and runs a vend/cancel/change sequence. A handshake with the change dispenser returns the remaining credit. It sits between the coin validator front end and the product dispenser / change-return logic.

Parameters:
CREDIT_W, 8, width of the credit, price and change datapaths
NICKEL_VAL, 5, value credited for coin_n
DIME_VAL, 10, value credited for coin_d
QUARTER_VAL, 25, value credited for coin_q
MAX_CREDIT, 200, maximum credit held; must be less than 2**CREDIT_W

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
coin_valid  in  1  validator qualifier; coin inputs are ignored when 0
coin_n  in  1  nickel inserted, one-cycle pulse
coin_d  in  1  dime inserted, one-cycle pulse
coin_q  in  1  quarter inserted, one-cycle pulse
price  in  CREDIT_W  price of the selected item, sampled on vend_req
vend_req  in  1  purchase request, one-cycle pulse
cancel  in  1  return-all-credit request, one-cycle pulse
change_ack  in  1  dispenser has taken change_amt
credit  out  CREDIT_W  current accumulated credit
coin_reject  out  1  one-cycle pulse: the coin was not credited
vend  out  1  one-cycle pulse: the item is released
vend_short  out  1  one-cycle pulse: vend_req arrived with credit < price
change_valid  out  1  change offer pending
change_amt  out  CREDIT_W  change value, stable while change_valid=1
busy  out  1  high in VEND or CHANGE state

Behaviour:
- Reset, checked before all else: state=COLLECT; credit=0; all pulse outputs=0; change_valid=0; change_amt=0; busy=0.
- Coin event: coin_valid=1 and any of coin_n/coin_d/coin_q=1.
  - Decode priority is N > D > Q; only one value is used per cycle.
  - The lower-priority coins present in the same cycle are dropped silently, with no reject.
  - coin_valid=0 ignores all coin inputs, with no reject.
- States: COLLECT, VEND, CHANGE.
- COLLECT, per cycle, priority cancel > vend_req > coin:
  - cancel: if credit>0, go to CHANGE with change_amt=credit; if credit=0, no action.
  - vend_req with credit>=price: go to VEND; credit <= credit-price, registered.
  - vend_req with credit<price: vend_short=1 next cycle; credit unchanged; stay in COLLECT.
  - Coin, when no cancel/vend_req: if credit+value <= MAX_CREDIT, credit <= credit+value next cycle; otherwise coin_reject=1 next cycle and credit unchanged.
  - A coin arriving in the same cycle as cancel or vend_req gets coin_reject=1 next cycle.
  - The addition uses CREDIT_W+1 bits internally; no wrap-around is permitted.
- VEND, one cycle:
  - vend=1.
  - If credit>0, go to CHANGE with change_amt=credit; otherwise go to COLLECT.
  - Any coin gets coin_reject; vend_req and cancel are ignored.
- CHANGE:
  - change_valid=1 and change_amt is held.
  - On change_ack=1: credit <= 0, change_valid <= 0, change_amt <= 0, go to COLLECT.
  - Any coin gets coin_reject; vend_req and cancel are ignored; there is no timeout.
  - change_ack outside CHANGE is ignored.
- Latency: every output is registered. Each response appears 1 cycle after the causing input edge.
- busy=1 while in VEND or CHANGE.
- credit remains visible through VEND and CHANGE until the ack clears it.
- Reset asserted mid-VEND or mid-CHANGE: abort to the reset state with credit lost.
- MAX_CREDIT boundary: reaching exactly MAX_CREDIT is accepted.

Test Plan:
- Reset, then N, D, Q on separate cycles -> credit goes 5, 15, 40; no rejects.
- Credit 40, price=35, vend_req -> vend=1, then change_valid=1 with change_amt=5; change_ack -> credit=0, state COLLECT, busy=0.
- Credit 15, price=25, vend_req -> vend_short=1, credit stays 15, no vend; then cancel -> change_amt=15; ack -> credit=0.
- Credit 190, Q -> coin_reject=1, credit stays 190; then D -> credit=200; then N -> coin_reject.
- Same cycle: coin_n=coin_q=1 -> credit +5 only; cancel+vend_req+coin_d at credit 25 -> CHANGE with change_amt=25 and coin_reject=1; coin during CHANGE -> coin_reject.
- Credit 30, price=30, vend_req -> vend=1, then direct return to COLLECT with no change_valid. Reset asserted while change_valid=1 -> all outputs 0 the next cycle.
